// File: rtl/uart_rx_pkg.sv
// Shared UART constants: bit timing, frame format and RX FSM encodings.
// The transmitter takes its bit period from the same default so both ends pair.
package uart_rx_pkg;

    localparam logic [11:0] C_BIT_CNT_DEF = 12'h364;
    localparam int          C_DATA_BITS   = 8;
    localparam int          C_STOP_BITS   = 1;

    typedef enum logic [3:0] {
        RX_IDLE  = 4'b0001,
        RX_START = 4'b0010,
        RX_DATA  = 4'b0100,
        RX_STOP  = 4'b1000
    } rx_state_e;

    // Mid-bit point, integer floor of half the terminal count
    function automatic logic [11:0] f_half_cnt(input logic [11:0] bit_cnt);
        return {1'b0, bit_cnt[11:1]};
    endfunction

    localparam logic [11:0] C_HALF_CNT_DEF = f_half_cnt(C_BIT_CNT_DEF);

endpackage

// File: rtl/uart_rx_if.sv
// Receiver pin and byte-delivery bundle.
// slave: the receiver; master: the pin driver / byte consumer.
interface uart_rx_if;

    logic       UART_RXD;
    logic [7:0] UART_RX_DATA;
    logic       UART_RX_VALID;
    logic       UART_RX_FERR;
    logic       UART_RX_BUSY;

    modport slave (
        input  UART_RXD,
        output UART_RX_DATA,
        output UART_RX_VALID,
        output UART_RX_FERR,
        output UART_RX_BUSY
    );

    modport master (
        output UART_RXD,
        input  UART_RX_DATA,
        input  UART_RX_VALID,
        input  UART_RX_FERR,
        input  UART_RX_BUSY
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RXD pin plus falling-edge detect.
// All flops reset high so the line reads idle out of reset.
module uart_rx_sync
    import uart_rx_pkg::*;
(
    input  logic CLK_100M,
    input  logic IO_RESET,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_start_edge
);

    logic r_META;
    logic r_SYNC;
    logic r_PREV;

    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            r_META <= 1'b1;
            r_SYNC <= 1'b1;
            r_PREV <= 1'b1;
        end else begin
            r_META <= i_rxd;
            r_SYNC <= r_META;
            r_PREV <= r_SYNC;
        end
    end

    assign o_rxd_s      = r_SYNC;
    assign o_start_edge = ~r_SYNC & r_PREV;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Emits a one-clock VALID per good byte or FERR per bad stop bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter logic [11:0] C_BIT_CNT = C_BIT_CNT_DEF
) (
    input  logic      CLK_100M,
    input  logic      IO_RESET,
    uart_rx_if.slave  io_uart
);

    localparam logic [11:0] C_HALF_CNT = f_half_cnt(C_BIT_CNT);
    localparam logic [2:0]  C_LAST_BIT = 3'(C_DATA_BITS - 1);

    rx_state_e   r_STATE;
    rx_state_e   w_NEXT;
    logic [11:0] r_RX_CNT;
    logic [2:0]  r_BIT_IDX;
    logic [7:0]  r_SHIFT;
    logic [7:0]  r_DATA;
    logic        r_VALID;
    logic        r_FERR;
    logic        r_BUSY;

    logic w_RXD_S;
    logic w_START_EDGE;
    logic w_HALF_HIT;
    logic w_BIT_HIT;
    logic w_SHIFT_EN;
    logic w_LOAD;
    logic w_FERR_SET;
    logic w_CNT_CLR;

    uart_rx_sync u_sync (
        .CLK_100M     (CLK_100M),
        .IO_RESET     (IO_RESET),
        .i_rxd        (io_uart.UART_RXD),
        .o_rxd_s      (w_RXD_S),
        .o_start_edge (w_START_EDGE)
    );

    assign w_HALF_HIT = (r_RX_CNT == C_HALF_CNT);
    assign w_BIT_HIT  = (r_RX_CNT == C_BIT_CNT);

    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) r_STATE <= RX_IDLE;
        else          r_STATE <= w_NEXT;
    end

    always_comb begin
        w_NEXT     = r_STATE;
        w_SHIFT_EN = 1'b0;
        w_LOAD     = 1'b0;
        w_FERR_SET = 1'b0;
        unique case (r_STATE)
            RX_IDLE: begin
                if (w_START_EDGE) w_NEXT = RX_START;
            end
            RX_START: begin
                if (w_HALF_HIT) w_NEXT = w_RXD_S ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_BIT_HIT) begin
                    w_SHIFT_EN = 1'b1;
                    if (r_BIT_IDX == C_LAST_BIT) w_NEXT = RX_STOP;
                end
            end
            RX_STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be seen
                if (w_BIT_HIT) begin
                    w_NEXT     = RX_IDLE;
                    w_LOAD     = w_RXD_S;
                    w_FERR_SET = ~w_RXD_S;
                end
            end
            default: w_NEXT = RX_IDLE;
        endcase
    end

    // Each data sample restarts the bit period as well as each state change
    assign w_CNT_CLR = (w_NEXT != r_STATE) | w_SHIFT_EN;

    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            r_RX_CNT  <= 12'd0;
            r_BIT_IDX <= 3'd0;
            r_SHIFT   <= 8'h00;
            r_DATA    <= 8'h00;
            r_VALID   <= 1'b0;
            r_FERR    <= 1'b0;
            r_BUSY    <= 1'b0;
        end else begin
            if (w_CNT_CLR)
                r_RX_CNT <= 12'd0;
            else if (r_STATE != RX_IDLE)
                r_RX_CNT <= r_RX_CNT + 12'd1;

            if (r_STATE != RX_DATA)
                r_BIT_IDX <= 3'd0;
            else if (w_SHIFT_EN)
                r_BIT_IDX <= r_BIT_IDX + 3'd1;

            if (w_SHIFT_EN) r_SHIFT <= {w_RXD_S, r_SHIFT[7:1]};
            if (w_LOAD)     r_DATA  <= r_SHIFT;

            r_VALID <= w_LOAD;
            r_FERR  <= w_FERR_SET;
            r_BUSY  <= (w_NEXT != RX_IDLE);
        end
    end

    assign io_uart.UART_RX_DATA  = r_DATA;
    assign io_uart.UART_RX_VALID = r_VALID;
    assign io_uart.UART_RX_FERR  = r_FERR;
    assign io_uart.UART_RX_BUSY  = r_BUSY;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a line-level decoder model predicts every output each
// cycle; a second instance runs one frame at the full 115200-baud setting.
module tb_uart_rx;

    import uart_rx_pkg::*;

    localparam logic [11:0] BIT_CNT = 12'd15;
    localparam int P    = 16;
    localparam int H    = 7;
    localparam int NMAX = 50000;

    logic CLK_100M = 1'b0;
    logic IO_RESET;
    logic rst2;

    always #5 CLK_100M = ~CLK_100M;

    uart_rx_if u_if ();
    uart_rx_if u_if2 ();

    uart_rx #(.C_BIT_CNT(BIT_CNT)) u_dut (
        .CLK_100M (CLK_100M),
        .IO_RESET (IO_RESET),
        .io_uart  (u_if.slave)
    );

    uart_rx u_dut_full (
        .CLK_100M (CLK_100M),
        .IO_RESET (rst2),
        .io_uart  (u_if2.slave)
    );

    bit         pin   [NMAX];
    bit         rst   [NMAX];
    bit         s_m   [NMAX];
    bit         e_v   [NMAX];
    bit         e_f   [NMAX];
    bit         e_b   [NMAX];
    bit         e_set [NMAX];
    logic [7:0] e_val [NMAX];
    logic [7:0] e_d   [NMAX];
    int n = 0;

    logic [8:0] intent_q [$];
    logic [8:0] ev_q [$];
    int         ev_cyc [$];

    int n_assert = 0;
    int n_fail   = 0;
    int cur      = 0;
    bit running  = 1'b0;
    bit done2    = 1'b0;
    int c55, g0, rchk, gl_busy = 0;
    logic [7:0] rst_data = 8'hEE;

    task automatic chk(input string nm, input int c, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    task automatic put(input bit lvl, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            pin[n] = lvl;
            rst[n] = 1'b0;
            n++;
        end
    endtask

    task automatic put_frame(input logic [7:0] b, input bit stop);
        put(1'b0, P);
        for (int i = 0; i < 8; i++) put(b[i], P);
        put(stop, P);
    endtask

    task automatic build();
        logic [7:0] b3 [3];
        logic [7:0] f0 = 8'h0F;
        int rs;
        b3[0] = 8'hA5; b3[1] = 8'h3C; b3[2] = 8'hFF;
        put(1'b1, 4);
        for (int i = 0; i < 4; i++) rst[i] = 1'b1;
        put(1'b1, 20);
        c55 = n;
        put_frame(8'h55, 1'b1); intent_q.push_back({1'b0, 8'h55});
        put(1'b1, 30);
        for (int i = 0; i < 3; i++) begin
            put_frame(b3[i], 1'b1);
            intent_q.push_back({1'b0, b3[i]});
        end
        put(1'b1, 30);
        g0 = n;
        put(1'b0, 5);
        put(1'b1, 40);
        put_frame(8'h81, 1'b0); intent_q.push_back(9'h100);
        put(1'b1, 30);
        put(1'b0, 13 * P); intent_q.push_back(9'h100);
        put(1'b1, 30);
        put_frame(8'h12, 1'b1); intent_q.push_back({1'b0, 8'h12});
        put(1'b1, 30);
        put(1'b0, P);
        for (int i = 0; i < 4; i++) put(f0[i], P);
        put(1'b0, 8);
        rs = n;
        put(1'b1, 4);
        for (int i = rs; i < rs + 4; i++) rst[i] = 1'b1;
        rchk = rs + 4;
        put(1'b1, 30);
        put_frame(8'hC3, 1'b1); intent_q.push_back({1'b0, 8'hC3});
        put(1'b1, 30);
        for (int i = 0; i < 256; i++) begin
            put_frame(8'(i), 1'b1);
            intent_q.push_back({1'b0, 8'(i)});
        end
        put(1'b1, 40);
    endtask

    function automatic int first_rst(input int lo, input int hi);
        for (int c = lo; c <= hi && c < n; c++)
            if (rst[c]) return c;
        return -1;
    endfunction

    task automatic mark_busy(input int lo, input int hi);
        for (int c = lo; c <= hi && c < n; c++) e_b[c] = 1'b1;
    endtask

    // Decode the synchronized line straight from the sampling rules:
    // start edge E, start check at E+1+H, bits every P, output one clock later.
    task automatic run_model();
        int t, e, hs, fend, rc;
        logic [7:0] b, d;
        for (int c = 0; c < n; c++)
            s_m[c] = (c == 0 || rst[c] || rst[c-1]) ? 1'b1 : pin[c-1];
        t = 0;
        while (t < n) begin
            if (rst[t]) begin
                t++;
            end else if (t > 0 && !s_m[t] && s_m[t-1]) begin
                e    = t;
                hs   = e + 1 + H;
                fend = e + 2 + H + 9 * P;
                if (fend >= n) break;
                rc = first_rst(e + 1, e + 2 + H);
                if (rc >= 0) begin
                    mark_busy(e + 1, rc - 1);
                    t = rc;
                end else if (s_m[hs]) begin
                    mark_busy(e + 1, e + 1 + H);
                    t = e + 2 + H;
                end else begin
                    rc = first_rst(e + 1, fend);
                    if (rc >= 0) begin
                        mark_busy(e + 1, rc - 1);
                        t = rc;
                    end else begin
                        mark_busy(e + 1, fend - 1);
                        for (int k = 1; k <= 8; k++) b[k-1] = s_m[hs + k * P];
                        if (s_m[hs + 9 * P]) begin
                            e_v[fend]   = 1'b1;
                            e_set[fend] = 1'b1;
                            e_val[fend] = b;
                        end else begin
                            e_f[fend] = 1'b1;
                        end
                        t = fend;
                    end
                end
            end else begin
                t++;
            end
        end
        d = 8'h00;
        for (int c = 0; c < n; c++) begin
            if (rst[c])        d = 8'h00;
            else if (e_set[c]) d = e_val[c];
            e_d[c] = d;
        end
    endtask

    always @(posedge CLK_100M) begin
        if (running) begin
            #1;
            chk("valid", cur, int'(u_if.UART_RX_VALID), int'(e_v[cur]));
            chk("ferr",  cur, int'(u_if.UART_RX_FERR),  int'(e_f[cur]));
            chk("busy",  cur, int'(u_if.UART_RX_BUSY),  int'(e_b[cur]));
            chk("data",  cur, int'(u_if.UART_RX_DATA),  int'(e_d[cur]));
            if (u_if.UART_RX_VALID) begin
                ev_q.push_back({1'b0, u_if.UART_RX_DATA});
                ev_cyc.push_back(cur);
            end
            if (u_if.UART_RX_FERR) begin
                ev_q.push_back(9'h100);
                ev_cyc.push_back(cur);
            end
            if (cur >= g0 && cur < g0 + 40 && u_if.UART_RX_BUSY) gl_busy++;
            if (cur == rchk) rst_data = u_if.UART_RX_DATA;
        end
    end

    // Full-rate instance: frame 0x96 whose start bit is applied before edge k=1.
    // Valid lands at k = 2 + 2 + 434 + 9*869 = 8259; busy spans k = 3..8258.
    initial begin
        logic [7:0] b2 = 8'h96;
        bit lvl;
        int j, nv;
        rst2 = 1'b1;
        u_if2.UART_RXD = 1'b1;
        repeat (4) @(negedge CLK_100M);
        rst2 = 1'b0;
        repeat (10) @(negedge CLK_100M);
        nv = 0;
        for (int k = 1; k <= 8300; k++) begin
            j = k - 1;
            if (j < 869)            lvl = 1'b0;
            else if (j < 869 * 9)   lvl = b2[j / 869 - 1];
            else                    lvl = 1'b1;
            u_if2.UART_RXD = lvl;
            @(posedge CLK_100M);
            #1;
            chk("full_valid", k, int'(u_if2.UART_RX_VALID), (k == 8259) ? 1 : 0);
            chk("full_ferr",  k, int'(u_if2.UART_RX_FERR), 0);
            chk("full_busy",  k, int'(u_if2.UART_RX_BUSY),
                (k >= 3 && k <= 8258) ? 1 : 0);
            if (u_if2.UART_RX_VALID) begin
                nv++;
                chk("full_data", k, int'(u_if2.UART_RX_DATA), 8'h96);
            end
            @(negedge CLK_100M);
        end
        chk("full_valid_count", 0, nv, 1);
        done2 = 1'b1;
    end

    initial begin
        int nf;
        IO_RESET = 1'b1;
        u_if.UART_RXD = 1'b1;
        build();
        run_model();
        for (int c = 0; c < n; c++) begin
            @(negedge CLK_100M);
            cur = c;
            u_if.UART_RXD = pin[c];
            IO_RESET = rst[c];
            running = 1'b1;
            @(posedge CLK_100M);
        end
        @(negedge CLK_100M);
        running = 1'b0;
        for (int i = 0; i < 20000 && !done2; i++) @(posedge CLK_100M);
        chk("full_run_done", 0, int'(done2), 1);

        chk("event_count", 0, ev_q.size(), intent_q.size());
        for (int i = 0; i < intent_q.size() && i < ev_q.size(); i++)
            chk("event", i, int'(ev_q[i]), int'(intent_q[i]));
        chk("first_valid_cycle", 0,
            (ev_cyc.size() > 0) ? ev_cyc[0] : -1, c55 + 1 + 2 + 7 + 9 * 16);
        chk("first_valid_model", c55 + 154, int'(e_v[c55 + 154]), 1);
        chk("glitch_busy_cycles", 0, gl_busy, 8);
        chk("data_after_reset", rchk, int'(rst_data), 8'h00);
        nf = 0;
        foreach (ev_q[i]) if (ev_q[i][8]) nf++;
        chk("ferr_total", 0, nf, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
